// File: rtl/seq_detect_pkg.sv
// ============================================================================
//  Module      : seq_detect_pkg
//  Description : Shared defaults and width helper for the serial pattern
//                detector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_detect_pkg;

  localparam int                     PAT_W_DEF   = 4;
  localparam logic [PAT_W_DEF-1:0]   PAT_RST_DEF = 4'b1011;
  localparam int                     CNT_W_DEF   = 8;

  // depth runs 0..pat_w inclusive, so it needs room for pat_w+1 values
  function automatic int depth_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage : seq_detect_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones; synchronous clear wins
//                over increment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/seq_detect_param.sv
// ============================================================================
//  Module      : seq_detect_param
//  Description : Serial bit-pattern detector with runtime-loadable pattern,
//                Moore and Mealy match flags and a saturating match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = CNT_W_DEF,
  localparam int              DEPTH_W = depth_w(PAT_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d,
  input  logic               d_valid,
  input  logic               pat_load,
  input  logic [PAT_W-1:0]   pat_in,
  input  logic               cnt_clr,
  output logic               q_moore,
  output logic               q_mealy,
  output logic [DEPTH_W-1:0] depth,
  output logic [CNT_W-1:0]   match_cnt
);

  // Only the newest PAT_W-1 bits are ever compared, so older bits are not kept.
  logic [PAT_W-2:0]   hist_q,    hist_d;
  logic [PAT_W-1:0]   pat_q,     pat_d;
  logic [DEPTH_W-1:0] depth_q,   depth_d;
  logic               q_moore_q, q_moore_d;

  logic [PAT_W-1:0]   w_shift;
  logic               w_match_cond;
  logic               w_match;
  logic [DEPTH_W-1:0] w_depth_inc;
  logic [DEPTH_W-1:0] w_depth_on_match;

  assign w_shift      = {hist_q, d};
  assign w_match_cond = (depth_q >= DEPTH_W'(PAT_W - 1)) && (w_shift == pat_q);
  assign w_match      = d_valid && !pat_load && w_match_cond;
  assign w_depth_inc  = (depth_q == DEPTH_W'(PAT_W)) ? depth_q
                                                     : depth_q + DEPTH_W'(1);

  generate
    if (OVERLAP) begin : g_overlap
      assign w_depth_on_match = w_depth_inc;
    end else begin : g_discard
      assign w_depth_on_match = '0;
    end
  endgenerate

  always_comb begin
    hist_d    = hist_q;
    pat_d     = pat_q;
    depth_d   = depth_q;
    q_moore_d = q_moore_q;
    if (pat_load) begin
      // A new pattern invalidates any history gathered for the old one.
      pat_d     = pat_in;
      depth_d   = '0;
      q_moore_d = 1'b0;
    end else if (d_valid) begin
      hist_d    = w_shift[PAT_W-2:0];
      q_moore_d = w_match_cond;
      depth_d   = w_match_cond ? w_depth_on_match : w_depth_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q    <= '0;
      pat_q     <= PAT_RST;
      depth_q   <= '0;
      q_moore_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      pat_q     <= pat_d;
      depth_q   <= depth_d;
      q_moore_q <= q_moore_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_match),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );

  assign q_moore = q_moore_q;
  assign q_mealy = w_match && !rst;
  assign depth   = depth_q;

endmodule : seq_detect_param

`default_nettype wire

// File: tb/tb_seq_detect_param.sv
// ============================================================================
//  Module      : tb_seq_detect_param
//  Description : Directed bench for seq_detect_param: default, non-overlap and
//                narrow-counter instances share one stimulus stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d = 1'b0;
  logic       d_valid = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       cnt_clr = 1'b0;

  logic       moore0, mealy0, moore1, mealy1, moore2, mealy2;
  logic [2:0] depth0, depth1, depth2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_dut_ov (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .q_moore(moore0), .q_mealy(mealy0),
    .depth(depth0), .match_cnt(cnt0));

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_dut_no (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .q_moore(moore1), .q_mealy(mealy1),
    .depth(depth1), .match_cnt(cnt1));

  seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_dut_c2 (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .q_moore(moore2), .q_mealy(mealy2),
    .depth(depth2), .match_cnt(cnt2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one bit a few time units after an edge so combinational outputs settle.
  task automatic set_bit(input logic b);
    d       = b;
    d_valid = 1'b1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    d_valid  = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic send(input logic b);
    set_bit(b);
    tick();
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i]);
    end
  endtask

  // Asserted and released between edges, so only the asynchronous path can act.
  task automatic pulse_rst(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_depth"}, 32'(depth0), 32'd0);
    chk({tag, "_moore"}, 32'(moore0), 32'd0);
    chk({tag, "_cnt"},   32'(cnt0),   32'd0);
    chk({tag, "_mealy"}, 32'(mealy0), 32'd0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // Initial reset across a few edges
    repeat (2) @(posedge clk);
    #1;
    pulse_rst("rst0");

    // Single 1011 match: Mealy in the completing cycle, Moore one clock later
    send_bits(16'b101, 3);
    set_bit(1'b1);
    chk("a_mealy_4th", 32'(mealy0), 32'd1);
    chk("a_moore_4th", 32'(moore0), 32'd0);
    tick();
    chk("a_moore_after", 32'(moore0), 32'd1);
    chk("a_cnt",         32'(cnt0),   32'd1);
    chk("a_depth",       32'(depth0), 32'd4);
    tick();
    chk("a_moore_hold",  32'(moore0), 32'd1);
    set_bit(1'b1);
    chk("a_mealy_nomatch", 32'(mealy0), 32'd0);
    tick();
    chk("a_moore_clear", 32'(moore0), 32'd0);

    // Overlapping vs non-overlapping on 1011011
    pulse_rst("rst_b");
    send_bits(16'b1011011, 7);
    chk("b_ov_cnt",   32'(cnt0),   32'd2);
    chk("b_ov_depth", 32'(depth0), 32'd4);
    chk("b_no_cnt",   32'(cnt1),   32'd1);
    chk("b_no_depth", 32'(depth1), 32'd3);

    // Gap with d_valid low holds all state
    pulse_rst("rst_c");
    send_bits(16'b10, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    chk("c_gap_depth", 32'(depth0), 32'd2);
    chk("c_gap_moore", 32'(moore0), 32'd0);
    chk("c_gap_cnt",   32'(cnt0),   32'd0);
    send_bits(16'b11, 2);
    chk("c_cnt",   32'(cnt0),   32'd1);
    chk("c_moore", 32'(moore0), 32'd1);

    // Five overlapping matches saturate a 2-bit counter; clear beats a match
    pulse_rst("rst_d");
    send_bits(16'b1011011011011011, 16);
    chk("d_cnt8", 32'(cnt0), 32'd5);
    chk("d_cnt2", 32'(cnt2), 32'd3);
    send_bits(16'b01, 2);
    set_bit(1'b1);
    cnt_clr = 1'b1;
    tick();
    chk("d_clr_cnt8",  32'(cnt0),   32'd0);
    chk("d_clr_cnt2",  32'(cnt2),   32'd0);
    chk("d_clr_moore", 32'(moore0), 32'd1);
    send_bits(16'b011, 3);
    chk("d_post_clr_cnt", 32'(cnt0), 32'd1);

    // Reset mid-sequence restarts detection from the next accepted bit
    pulse_rst("rst_e");
    send_bits(16'b101, 3);
    pulse_rst("rst_e2");
    send(1'b1);
    chk("e_depth1", 32'(depth0), 32'd1);
    chk("e_cnt0",   32'(cnt0),   32'd0);
    send_bits(16'b011, 3);
    chk("e_cnt1", 32'(cnt0), 32'd1);

    // Runtime pattern load discards the coincident bit
    pat_in   = 4'b0110;
    pat_load = 1'b1;
    set_bit(1'b1);
    tick();
    chk("e_load_depth", 32'(depth0), 32'd0);
    chk("e_load_moore", 32'(moore0), 32'd0);
    chk("e_load_cnt",   32'(cnt0),   32'd1);

    // Load coinciding with a would-be match suppresses Mealy and the count
    send_bits(16'b011, 3);
    pat_load = 1'b1;
    set_bit(1'b0);
    chk("e_mealy_load", 32'(mealy0), 32'd0);
    tick();
    chk("e_load2_depth", 32'(depth0), 32'd0);
    chk("e_load2_cnt",   32'(cnt0),   32'd1);

    send_bits(16'b011, 3);
    set_bit(1'b0);
    chk("e_mealy_0110", 32'(mealy0), 32'd1);
    tick();
    chk("e_cnt2",  32'(cnt0),   32'd2);
    chk("e_moore", 32'(moore0), 32'd1);

    // Reset restores the default pattern
    pulse_rst("rst_f");
    send_bits(16'b1011, 4);
    chk("f_cnt", 32'(cnt0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seq_detect_param

`default_nettype wire
